// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and default sizing for the TX FIFO write-port arbiter.
package tx_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/tx_arb_rr_pick.sv
// tx_arb_rr_pick: combinational round-robin selector. Searches upward from
// last_owner+1 with wrap and returns a one-hot pick plus an any-valid flag.
module tx_arb_rr_pick
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last_owner,
    output logic [NUM_REQ-1:0] o_pick,
    output logic               o_any
);

    logic w_found;

    // First requester after the previous owner wins; the previous owner is checked last.
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && i_req[(int'(i_last_owner) + k) % NUM_REQ]) begin
                o_pick[(int'(i_last_owner) + k) % NUM_REQ] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: packet-granular round-robin arbiter in front of a TX FIFO write port.
// A grant is locked for a whole packet (until req_last) and one idle bubble
// separates packets. Optional stall watchdog: define TX_ARB_TIMEOUT_EN.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               r_state, w_next;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        r_last_owner;
    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_any;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_xfer;
    logic                 w_done;
    logic                 w_timeout;

    tx_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_req        (req_valid),
        .i_last_owner (r_last_owner),
        .o_pick       (w_pick),
        .o_any        (w_any)
    );

    // Binary index of the one-hot pick, kept so the owner slice is a plain mux.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = IW'(i);
        end
    end

    assign w_xfer = (r_state == ST_LOCKED) && req_valid[r_owner] && !fifo_full;
    assign w_done = w_xfer && req_last[r_owner];
    assign grant  = r_grant;

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state: lock on any request, release on last byte or watchdog expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_next = ST_LOCKED;
            ST_LOCKED: if (w_done || w_timeout) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs: only the locked owner can move a byte, and only when the FIFO has room.
    always_comb begin
        fifo_we    = w_xfer;
        req_ready  = w_xfer ? r_grant : '0;
        fifo_wdata = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grant/owner bookkeeping; last_owner starts at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IW'(NUM_REQ - 1);
        end else if (r_state == ST_IDLE) begin
            if (w_any) begin
                r_grant <= w_pick;
                r_owner <= w_pick_idx;
            end
        end else if (w_done || w_timeout) begin
            r_grant      <= '0;
            r_last_owner <= r_owner;
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_timeout_err;

    // Expiry on the TIMEOUT_CYCLES-th consecutive cycle the owner has nothing to offer.
    assign w_timeout = (r_state == ST_LOCKED) && !req_valid[r_owner] &&
                       (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts owner-idle cycles only; FIFO-full stalls neither count nor clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state != ST_LOCKED || w_xfer || w_timeout) r_to_cnt <= '0;
            else if (!req_valid[r_owner])                    r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;

    // Without the watchdog a locked grant is held indefinitely.
    assign w_timeout    = 1'b0;
    assign timeout_err  = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule
